// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage core.
// It arbitrates stall requests from ID and EX. It counts how many cycles a
// multi-cycle EX op still occupies the stage. It also sequences exception
// flushes: the pipe is frozen for one cycle, then flushed for one cycle.
// Outputs:
//   stall    - per-stage hold vector, contiguous from bit0 (PC).
//   flush    - clear every pipeline register to NOP.
//   new_pc   - redirect target to load while flush is high.
//   mc_busy  - a multi-cycle op is in progress.
//   mc_last  - final EX cycle of a multi-cycle op; the EX result is valid.
//   mc_abort - one-cycle pulse when a running op is killed by an exception.
module pipe_ctrl #(
  parameter int MC_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_from_id,
  input  logic                ex_mc_start,
  input  logic [MC_CNT_W-1:0] ex_mc_cycles,
  input  logic                excp_valid,
  input  logic [31:0]         excp_handler,
  output logic [5:0]          stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic                mc_busy,
  output logic                mc_last,
  output logic                mc_abort
);

  // Stall vectors; bit0 is PC and the hold always extends upward from it.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  localparam logic [MC_CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [MC_CNT_W-1:0] CNT_ONE  = {{(MC_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MC_BUSY = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [MC_CNT_W-1:0] cnt, cnt_nx;
  logic [31:0]         new_pc_nx;
  logic                mc_abort_nx;

  // State, remaining-occupancy counter, redirect target and abort pulse.
  // Reset is asynchronous so the outputs drop without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= CNT_ZERO;
      new_pc   <= 32'h0;
      mc_abort <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      new_pc   <= new_pc_nx;
      mc_abort <= mc_abort_nx;
    end
  end

  // Next-state logic and the zero-latency stall/flush/mc_last outputs.
  // Priority, highest first: FLUSH, then exception, then a multi-cycle op,
  // then the ID load-use request.
  // In MC_BUSY, cnt holds the occupancy cycles left after the current one
  // plus one, so cnt==1 marks the final EX cycle.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    new_pc_nx   = new_pc;
    mc_abort_nx = 1'b0;
    stall       = STALL_NONE;
    flush       = 1'b0;
    mc_last     = 1'b0;

    unique case (state)
      FLUSH: begin
        // MEM is being cleared, so a late exception or start is dropped.
        flush    = 1'b1;
        cnt_nx   = CNT_ZERO;
        state_nx = IDLE;
      end

      MC_BUSY: begin
        if (excp_valid) begin
          // Freeze everything for one cycle and kill the running op.
          stall       = STALL_ALL;
          cnt_nx      = CNT_ZERO;
          new_pc_nx   = excp_handler;
          mc_abort_nx = 1'b1;
          state_nx    = FLUSH;
        end else begin
          // A new ex_mc_start is ignored here; the count is never reloaded.
          // A concurrent ID request is covered by the wider EX stall.
          stall  = STALL_EX;
          cnt_nx = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            mc_last  = 1'b1;
            state_nx = IDLE;
          end
        end
      end

      default: begin // IDLE
        if (excp_valid) begin
          // The exception wins over a same-cycle start.
          // No op was running, so there is no abort pulse.
          stall     = STALL_ALL;
          new_pc_nx = excp_handler;
          state_nx  = FLUSH;
        end else if (ex_mc_start && (ex_mc_cycles != CNT_ZERO)) begin
          // The start cycle is occupancy cycle 1.
          // A one-cycle op therefore completes here.
          stall = STALL_EX;
          if (ex_mc_cycles == CNT_ONE) begin
            mc_last = 1'b1;
          end else begin
            cnt_nx   = ex_mc_cycles - CNT_ONE;
            state_nx = MC_BUSY;
          end
        end else if (stallreq_from_id) begin
          stall = STALL_ID;
        end
      end
    endcase
  end

  // mc_busy is taken directly from the state register.
  assign mc_busy = (state == MC_BUSY);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl.
// Inputs change on the falling edge. Outputs are sampled 1ns later, which is
// mid-cycle and well clear of the rising edge. Each falling edge is therefore
// one pipeline cycle.
module tb_pipe_ctrl;

  localparam int MC_CNT_W = 6;

  logic                clk;
  logic                rst;
  logic                stallreq_from_id;
  logic                ex_mc_start;
  logic [MC_CNT_W-1:0] ex_mc_cycles;
  logic                excp_valid;
  logic [31:0]         excp_handler;
  logic [5:0]          stall;
  logic                flush;
  logic [31:0]         new_pc;
  logic                mc_busy;
  logic                mc_last;
  logic                mc_abort;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.MC_CNT_W(MC_CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (stallreq_from_id),
    .ex_mc_start      (ex_mc_start),
    .ex_mc_cycles     (ex_mc_cycles),
    .excp_valid       (excp_valid),
    .excp_handler     (excp_handler),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .mc_busy          (mc_busy),
    .mc_last          (mc_last),
    .mc_abort         (mc_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Check the five status outputs of the current cycle against expected values.
  task automatic chk_o(input string tag, input logic [5:0] s, input logic f,
                       input logic b, input logic l, input logic a);
    chk({tag, ".stall"},    {26'd0, stall}, {26'd0, s});
    chk({tag, ".flush"},    {31'd0, flush}, {31'd0, f});
    chk({tag, ".mc_busy"},  {31'd0, mc_busy}, {31'd0, b});
    chk({tag, ".mc_last"},  {31'd0, mc_last}, {31'd0, l});
    chk({tag, ".mc_abort"}, {31'd0, mc_abort}, {31'd0, a});
  endtask

  // Advance one cycle and apply the given inputs.
  task automatic cyc(input logic sr, input logic st, input int n,
                     input logic ev, input logic [31:0] h);
    @(negedge clk);
    stallreq_from_id = sr;
    ex_mc_start      = st;
    ex_mc_cycles     = MC_CNT_W'(n);
    excp_valid       = ev;
    excp_handler     = h;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    stallreq_from_id = 1'b0;
    ex_mc_start = 1'b0;
    ex_mc_cycles = '0;
    excp_valid = 1'b0;
    excp_handler = 32'h0;

    // Reset state while rst is held low.
    #3;
    chk_o("rst", 6'b000000, 0, 0, 0, 0);
    chk("rst.new_pc", new_pc, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 1: idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 32'h0);
      chk_o($sformatf("idle%0d", i), 6'b000000, 0, 0, 0, 0);
    end
    chk("idle.new_pc", new_pc, 32'h0);

    // 2: ID load-use request for two cycles.
    cyc(1, 0, 0, 0, 32'h0); chk_o("id0", 6'b000111, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 32'h0); chk_o("id1", 6'b000111, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0); chk_o("id2", 6'b000000, 0, 0, 0, 0);

    // 3a: N=5.
    // T+1 adds an ID request; the vector stays 001111.
    // T+2 adds a start with N=9; it is ignored and the count is not reloaded.
    cyc(0, 1, 5, 0, 32'h0); chk_o("n5.t0", 6'b001111, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 32'h0); chk_o("n5.t1", 6'b001111, 0, 1, 0, 0);
    cyc(0, 1, 9, 0, 32'h0); chk_o("n5.t2", 6'b001111, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 32'h0); chk_o("n5.t3", 6'b001111, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 32'h0); chk_o("n5.t4", 6'b001111, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 32'h0); chk_o("n5.t5", 6'b000000, 0, 0, 0, 0);

    // 3b: N=1. A single stall cycle, with mc_last in the same cycle.
    cyc(0, 1, 1, 0, 32'h0); chk_o("n1.t0", 6'b001111, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 32'h0); chk_o("n1.t1", 6'b000000, 0, 0, 0, 0);

    // 3c: N=0. The start is ignored.
    cyc(0, 1, 0, 0, 32'h0); chk_o("n0.t0", 6'b000000, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0); chk_o("n0.t1", 6'b000000, 0, 0, 0, 0);

    // 4: N=8, with an exception at T+3.
    cyc(0, 1, 8, 0, 32'h0);     chk_o("ab.t0", 6'b001111, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0);     chk_o("ab.t1", 6'b001111, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 32'h0);     chk_o("ab.t2", 6'b001111, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 32'h180);   chk_o("ab.t3", 6'b111111, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 32'h0);     chk_o("ab.t4", 6'b000000, 1, 0, 0, 1);
    chk("ab.t4.new_pc", new_pc, 32'h180);
    cyc(0, 0, 0, 0, 32'h0);     chk_o("ab.t5", 6'b000000, 0, 0, 0, 0);
    chk("ab.t5.new_pc", new_pc, 32'h180);

    // 5: exception, start (N=4) and ID request all in one IDLE cycle.
    // The exception wins. In the FLUSH cycle, inputs are ignored:
    // a further exception (0x300), a start and an ID request.
    cyc(1, 1, 4, 1, 32'h200);   chk_o("ex.t0", 6'b111111, 0, 0, 0, 0);
    cyc(1, 1, 4, 1, 32'h300);   chk_o("ex.t1", 6'b000000, 1, 0, 0, 0);
    chk("ex.t1.new_pc", new_pc, 32'h200);
    cyc(0, 0, 0, 0, 32'h0);     chk_o("ex.t2", 6'b000000, 0, 0, 0, 0);
    chk("ex.t2.new_pc", new_pc, 32'h200);
    cyc(0, 0, 0, 0, 32'h0);     chk_o("ex.t3", 6'b000000, 0, 0, 0, 0);

    // 6: asynchronous reset mid-op, in the T+2 cycle where cnt=3.
    cyc(0, 1, 5, 0, 32'h0);     chk_o("ar.t0", 6'b001111, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0);     chk_o("ar.t1", 6'b001111, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 32'h0);     chk_o("ar.t2", 6'b001111, 0, 1, 0, 0);
    #1 rst = 1'b0;
    #1;
    chk_o("ar.rst", 6'b000000, 0, 0, 0, 0);
    chk("ar.rst.new_pc", new_pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 1, 2, 0, 32'h0);     chk_o("n2.t0", 6'b001111, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0);     chk_o("n2.t1", 6'b001111, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 32'h0);     chk_o("n2.t2", 6'b000000, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
